// File: rtl/fat32_sector_emitter_if.sv
// rtl/fat32_sector_emitter_if.sv - sector byte stream and source-sector read bus
//
// Purpose: groups the emitted byte stream and the source-buffer read port.
// Ports (master = emitter side):
//   src_address  master->slave  read address into the source sector buffer
//   src_byte     slave->master  source byte, combinational from src_address
//   out_valid    master->slave  out_byte/out_address valid
//   out_ready    slave->master  sink accepts on out_valid && out_ready
//   out_address  master->slave  byte address 0..511
//   out_byte     master->slave  emitted byte
//   out_last     master->slave  high with the byte at address 511
interface fat32_sector_emitter_if;
  logic [8:0] src_address;
  logic [7:0] src_byte;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_address;
  logic [7:0] out_byte;
  logic       out_last;

  modport master (
    output src_address,
    input  src_byte,
    output out_valid,
    input  out_ready,
    output out_address,
    output out_byte,
    output out_last
  );

  modport slave (
    input  src_address,
    output src_byte,
    input  out_valid,
    output out_ready,
    input  out_address,
    input  out_byte,
    input  out_last
  );
endinterface

// File: rtl/fat32_sector_emitter.sv
// rtl/fat32_sector_emitter.sv - merges a source sector with one FAT32 dir entry or FAT chain
//
// Purpose: streams a 512-byte sector for the SD write path. Each byte is the
// source-sector byte unless it falls inside the generated record: one 32-byte
// directory entry (mode 0) or the FAT entries of a contiguous cluster chain (mode 1).
// Ports:
//   Clock, sys_rst_n    clock, asynchronous active-low reset
//   start               1-cycle request, ignored while busy
//   mode                0 = directory entry, 1 = FAT chain
//   entry_slot          mode 0 entry index (byte base = slot*32)
//   file_name           mode 0 8.3 name, byte 0 in [87:80]
//   start_cluster       first cluster of the file
//   file_size           mode 0 size in bytes
//   chain_length        mode 1 number of clusters
//   fat_sector_idx      mode 1 FAT sector k (clusters 128k..128k+127)
//   busy, done          request in flight / 1-cycle completion pulse
//   bus                 stream and source-read bus (master side)
module fat32_sector_emitter #(
  parameter int          SectorBytes   = 512,
  parameter logic [7:0]  FileAttribute = 8'h20,
  parameter logic [31:0] FileTimeDate  = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [3:0]  entry_slot,
  input  logic [87:0] file_name,
  input  logic [31:0] start_cluster,
  input  logic [31:0] file_size,
  input  logic [31:0] chain_length,
  input  logic [31:0] fat_sector_idx,
  output logic        busy,
  output logic        done,
  fat32_sector_emitter_if.master bus
);

  localparam logic [8:0] LastAddr = 9'(SectorBytes - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t      state;
  logic        mode_q;
  logic [3:0]  slot_q;
  logic [87:0] name_q;
  logic [31:0] cluster_q;
  logic [31:0] size_q;
  logic [31:0] length_q;
  logic [31:0] sector_q;
  logic [31:0] chain_end_q;
  logic        chain_en_q;
  logic [8:0]  addr_q;
  logic        valid_q;
  logic        last_q;

  // Last cluster of the chain in 33 bits so a chain running past 2^32-1 is
  // detected instead of wrapping; it is clamped to 2^32-1 in LOAD.
  logic [32:0] end_sum;
  assign end_sum = {1'b0, cluster_q} + {1'b0, length_q} - 33'd1;

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      slot_q      <= '0;
      name_q      <= '0;
      cluster_q   <= '0;
      size_q      <= '0;
      length_q    <= '0;
      sector_q    <= '0;
      chain_end_q <= '0;
      chain_en_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            slot_q    <= entry_slot;
            name_q    <= file_name;
            cluster_q <= start_cluster;
            size_q    <= file_size;
            length_q  <= chain_length;
            sector_q  <= fat_sector_idx;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          chain_en_q  <= |length_q;
          chain_end_q <= end_sum[32] ? 32'hFFFF_FFFF : end_sum[31:0];
          addr_q      <= '0;
          valid_q     <= 1'b1;
          last_q      <= (LastAddr == 9'd0);
          state       <= EMIT;
        end
        EMIT: begin
          if (valid_q && bus.out_ready) begin
            if (addr_q == LastAddr) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              addr_q <= addr_q + 9'd1;
              last_q <= ((addr_q + 9'd1) == LastAddr);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Directory-entry field offset within the slot and the name byte at that offset.
  logic [4:0]  ofs;
  logic [87:0] name_sh;
  assign ofs     = addr_q[4:0];
  assign name_sh = name_q << {ofs, 3'b000};

  // FAT view: cluster number of the current 4-byte entry, kept wide enough that
  // large sector indices never alias onto small cluster numbers.
  logic [39:0] cluster_c;
  logic        in_chain;
  logic [31:0] fat_val;
  logic [7:0]  fat_byte;
  assign cluster_c = {1'b0, sector_q, 7'b0} + {33'b0, addr_q[8:2]};
  assign in_chain  = chain_en_q
                   && (cluster_c >= {8'b0, cluster_q})
                   && (cluster_c <= {8'b0, chain_end_q});
  assign fat_val   = (cluster_c[31:0] == chain_end_q) ? 32'h0FFF_FFFF
                                                      : cluster_c[31:0] + 32'd1;
  assign fat_byte  = fat_val[{addr_q[1:0], 3'b000} +: 8];

  logic [7:0] byte_c;
  always_comb begin
    byte_c = bus.src_byte;
    if (!mode_q) begin
      if (addr_q[8:5] == slot_q) begin
        if (ofs <= 5'h0A)      byte_c = name_sh[87:80];
        else if (ofs == 5'h0B) byte_c = FileAttribute;
        else if (ofs <= 5'h13) byte_c = 8'h00;
        else begin
          case (ofs)
            5'h14:   byte_c = cluster_q[23:16];
            5'h15:   byte_c = cluster_q[31:24];
            5'h16:   byte_c = FileTimeDate[7:0];
            5'h17:   byte_c = FileTimeDate[15:8];
            5'h18:   byte_c = FileTimeDate[23:16];
            5'h19:   byte_c = FileTimeDate[31:24];
            5'h1A:   byte_c = cluster_q[7:0];
            5'h1B:   byte_c = cluster_q[15:8];
            5'h1C:   byte_c = size_q[7:0];
            5'h1D:   byte_c = size_q[15:8];
            5'h1E:   byte_c = size_q[23:16];
            default: byte_c = size_q[31:24];
          endcase
        end
      end
    end else if (in_chain) begin
      byte_c = fat_byte;
    end
  end

  assign bus.src_address = addr_q;
  assign bus.out_address = addr_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_last    = last_q;
  assign bus.out_byte    = byte_c;

endmodule
